// File: rtl/seven_segment_scanner_if.sv
// Bus between the display scanner, its value source and the hex-to-segment decoder.
// The master side drives the value and strobe; the slave side is the scanner.
interface seven_segment_scanner_if;
  logic [31:0] val_in;
  logic        val_valid_in;
  logic [6:0]  seg_in;
  logic [3:0]  nibble_out;
  logic [6:0]  cat_out;
  logic [7:0]  an_out;
  logic        pending_out;

  modport master (
    output val_in, val_valid_in, seg_in,
    input  nibble_out, cat_out, an_out, pending_out
  );

  modport slave (
    input  val_in, val_valid_in, seg_in,
    output nibble_out, cat_out, an_out, pending_out
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Eight-digit 7-segment time-multiplexer with a shadow value, tear-free frame commit,
// anti-ghosting blank phase at the start of every slot and optional leading-zero blanking.
module seven_segment_scanner #(
  parameter int COUNT_PERIOD = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_BLANK     = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  seven_segment_scanner_if.slave bus
);
  localparam int CW = $clog2(COUNT_PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    d_q, d_d;
  logic [31:0]   disp_q, disp_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    cat_q, cat_d;

  logic          slot_end;
  logic          frame_end;
  logic          drive;
  logic          suppress;
  logic [4:0]    sh;

  always_comb begin
    sh        = {d_q, 2'b00};
    slot_end  = (cnt_q == CW'(COUNT_PERIOD - 1));
    frame_end = slot_end && (d_q == 3'd7);

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    d_d   = slot_end ? d_q + 3'd1 : d_q;

    shadow_d  = bus.val_valid_in ? bus.val_in : shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    // A strobe landing on the boundary itself goes straight to the display.
    if (frame_end) begin
      pending_d = 1'b0;
      if (bus.val_valid_in) begin
        disp_d = bus.val_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end else if (bus.val_valid_in) begin
      pending_d = 1'b1;
    end

    drive    = (BLANK_CYCLES == 0) || (32'(cnt_q) >= BLANK_CYCLES);
    suppress = (LZ_BLANK != 0) && (d_q != 3'd0) && ((disp_q >> sh) == 32'd0);

    an_d  = 8'hFF;
    cat_d = 7'h7F;
    if (drive && !suppress) begin
      an_d  = ~(8'b1 << d_q);
      cat_d = ~bus.seg_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      d_q       <= 3'd0;
      disp_q    <= 32'd0;
      shadow_q  <= 32'd0;
      pending_q <= 1'b0;
      an_q      <= 8'hFF;
      cat_q     <= 7'h7F;
    end else begin
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      cat_q     <= cat_d;
    end
  end

  assign bus.nibble_out  = disp_q[sh +: 4];
  assign bus.an_out      = an_q;
  assign bus.cat_out     = cat_q;
  assign bus.pending_out = pending_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: two instances (leading-zero blanking on and off) share one
// stimulus stream and are checked every cycle against a time-indexed reference model.
module tb_seven_segment_scanner;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int FR = 8 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] val;

  int checks = 0;
  int failures = 0;

  seven_segment_scanner_if ifc1 ();
  seven_segment_scanner_if ifc0 ();

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] lut [16];
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return lut[n];
  endfunction

  assign ifc1.val_in       = val;
  assign ifc1.val_valid_in = valid;
  assign ifc1.seg_in       = dec(ifc1.nibble_out);
  assign ifc0.val_in       = val;
  assign ifc0.val_valid_in = valid;
  assign ifc0.seg_in       = dec(ifc0.nibble_out);

  seven_segment_scanner #(.COUNT_PERIOD(P), .BLANK_CYCLES(B), .LZ_BLANK(1)) dut (
    .clk_in(clk), .rst_in(rst), .bus(ifc1.slave));
  seven_segment_scanner #(.COUNT_PERIOD(P), .BLANK_CYCLES(B), .LZ_BLANK(0)) dut_nz (
    .clk_in(clk), .rst_in(rst), .bus(ifc0.slave));

  always #5 clk = ~clk;

  // Reference state: cycles since reset plus the three value registers.
  int unsigned m_t = 0;
  logic [31:0] m_shadow = '0;
  logic [31:0] m_disp = '0;
  bit          m_pend = 1'b0;
  int          last_d = -1;
  int          last_c = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [31:0] x);
    int unsigned c, d, nd;
    bit lit0, lit1;
    logic [3:0] nib;
    logic [7:0] e_an1, e_an0;
    logic [6:0] e_cat1, e_cat0;
    rst = r; valid = v; val = x;
    c   = m_t % P;
    d   = (m_t / P) % 8;
    nib = m_disp[4*d +: 4];
    lit0 = !r && (c >= B);
    lit1 = lit0 && ((d == 0) || ((m_disp >> (4*d)) != 0));
    e_an0  = lit0 ? ~(8'd1 << d) : 8'hFF;
    e_cat0 = lit0 ? ~dec(nib) : 7'h7F;
    e_an1  = lit1 ? ~(8'd1 << d) : 8'hFF;
    e_cat1 = lit1 ? ~dec(nib) : 7'h7F;
    if (r) begin
      m_t = 0; m_shadow = '0; m_disp = '0; m_pend = 0; last_d = -1; last_c = -1;
    end else begin
      if (m_t % FR == FR - 1) begin
        if (v) m_disp = x;
        else if (m_pend) m_disp = m_shadow;
        m_pend = 0;
      end else if (v) begin
        m_pend = 1;
      end
      if (v) m_shadow = x;
      m_t++;
      last_d = int'(d);
      last_c = int'(c);
    end
    @(posedge clk);
    @(negedge clk);
    nd = (m_t / P) % 8;
    chk("an_lz",     ifc1.an_out, e_an1);
    chk("cat_lz",    ifc1.cat_out, e_cat1);
    chk("pend_lz",   ifc1.pending_out, m_pend);
    chk("nib_lz",    ifc1.nibble_out, m_disp[4*nd +: 4]);
    chk("onehot_lz", $countones(~ifc1.an_out) <= 1, 1);
    chk("an_nz",     ifc0.an_out, e_an0);
    chk("cat_nz",    ifc0.cat_out, e_cat0);
    chk("pend_nz",   ifc0.pending_out, m_pend);
    chk("onehot_nz", $countones(~ifc0.an_out) <= 1, 1);
  endtask

  // Idle until the outputs just registered came from slot position (d, c).
  task automatic run_until_out(input int d, input int c, input string tag);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle(0, 0, 32'd0);
      if (last_d == d && last_c == c) found = 1;
    end
    if (!found) begin
      failures++;
      $display("FAIL %s timeout waiting for digit %0d cnt %0d", tag, d, c);
    end
  endtask

  task automatic wait_commit(input string tag);
    int n = 0;
    while (ifc1.pending_out === 1'b1 && n < 200) begin
      cycle(0, 0, 32'd0);
      n++;
    end
    if (ifc1.pending_out !== 1'b0) begin
      failures++;
      $display("FAIL %s timeout waiting for commit, pending=%b", tag, ifc1.pending_out);
    end
  endtask

  typedef struct {
    bit          r;
    bit          v;
    logic [31:0] x;
    logic [7:0]  an;
    logic [6:0]  cat;
    bit          pend;
  } vec_t;

  vec_t tbl [12];

  initial begin
    rst = 1'b1; valid = 1'b0; val = '0;

    tbl[0] = '{1'b1, 1'b0, 32'h0, 8'hFF, 7'h7F, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 8'hFF, 7'h7F, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0, 8'hFF, 7'h7F, 1'b0};
    for (int i = 3; i <= 8; i++) tbl[i] = '{1'b0, 1'b0, 32'h0, 8'hFE, 7'h40, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 8'hFF, 7'h7F, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 8'hFF, 7'h7F, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_00A5, 8'hFF, 7'h7F, 1'b1};

    cycle(1, 0, 32'd0);
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].x);
      chk("tbl_an",   ifc1.an_out, tbl[i].an);
      chk("tbl_cat",  ifc1.cat_out, tbl[i].cat);
      chk("tbl_pend", ifc1.pending_out, tbl[i].pend);
    end

    // 0xA5: digits 0 and 1 lit after the boundary, rest dark.
    wait_commit("a5");
    run_until_out(0, 3, "a5_d0");
    chk("a5_d0_an", ifc1.an_out, 8'hFE);
    chk("a5_d0_cat", ifc1.cat_out, 7'h12);
    run_until_out(1, 3, "a5_d1");
    chk("a5_d1_an", ifc1.an_out, 8'hFD);
    chk("a5_d1_cat", ifc1.cat_out, 7'h08);
    run_until_out(2, 3, "a5_d2");
    chk("a5_d2_dark", ifc1.an_out, 8'hFF);

    // Last write wins.
    run_until_out(3, 1, "lww_pos");
    cycle(0, 1, 32'h8765_4321);
    cycle(0, 0, 32'd0);
    cycle(0, 1, 32'h1234_5678);
    wait_commit("lww");
    run_until_out(0, 3, "lww_d0");
    chk("lww_d0_cat", ifc1.cat_out, 7'h00);
    run_until_out(7, 3, "lww_d7");
    chk("lww_d7_an", ifc1.an_out, 8'h7F);
    chk("lww_d7_cat", ifc1.cat_out, 7'h79);

    // Strobe in the boundary cycle bypasses the shadow.
    while (m_t % FR != FR - 1) cycle(0, 0, 32'd0);
    cycle(0, 1, 32'h0000_0042);
    chk("byp_pend", ifc1.pending_out, 1'b0);
    run_until_out(0, 3, "byp_d0");
    chk("byp_d0_cat", ifc1.cat_out, 7'h24);
    run_until_out(1, 3, "byp_d1");
    chk("byp_d1_an", ifc1.an_out, 8'hFD);
    chk("byp_d1_cat", ifc1.cat_out, 7'h19);

    // Value 0: blanking instance shows only digit 0, the other all eight.
    cycle(0, 1, 32'd0);
    wait_commit("zero");
    run_until_out(5, 3, "zero_d5");
    chk("zero_nz_an", ifc0.an_out, 8'hDF);
    chk("zero_nz_cat", ifc0.cat_out, 7'h40);
    chk("zero_lz_an", ifc1.an_out, 8'hFF);

    // Reset mid-slot with a value pending.
    cycle(0, 1, 32'h0000_0099);
    cycle(0, 0, 32'd0);
    cycle(0, 0, 32'd0);
    cycle(1, 0, 32'd0);
    chk("rst_an", ifc1.an_out, 8'hFF);
    chk("rst_cat", ifc1.cat_out, 7'h7F);
    chk("rst_pend", ifc1.pending_out, 1'b0);
    run_until_out(0, 3, "rst_d0");
    chk("rst_d0_an", ifc1.an_out, 8'hFE);
    chk("rst_d0_cat", ifc1.cat_out, 7'h40);
    run_until_out(1, 3, "rst_d1");
    chk("rst_d1_dark", ifc1.an_out, 8'hFF);

    // Random traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      bit r, v;
      logic [31:0] x;
      r = ($urandom_range(0, 599) == 0);
      v = ($urandom_range(0, 15) == 0);
      x = $urandom() >> (4 * $urandom_range(0, 8));
      cycle(r, v, x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Time-multiplexing driver for the 8-digit 7-segment display, sitting directly upstream of the hex-to-segment decoder. It accepts a 32-bit value through a valid strobe and holds it in a shadow register. The shadow value is committed to the display only at frame boundaries, so a frame never tears. It scans digits round-robin, presents the selected nibble to the decoder, takes back the decoder's active-high segment vector, and drives active-low anodes and cathodes with anti-ghosting blanking and optional leading-zero suppression.

Parameters:
COUNT_PERIOD, 100000, clock cycles each digit is selected (must be >= 2).
BLANK_CYCLES, 1000, cycles at the start of each digit slot with all anodes off (0 <= BLANK_CYCLES < COUNT_PERIOD).
LZ_BLANK, 1, 1 = suppress leading zero digits, 0 = show all 8 digits.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  reset, synchronous to clk_in, active-high.
val_in  input  32  value to display; nibble k goes to digit k, where digit 0 is the rightmost.
val_valid_in  input  1  one-cycle strobe that captures val_in into the shadow register.
seg_in  input  7  active-high segments from the decoder; bit0 = a … bit6 = g.
nibble_out  output  4  digit value to the decoder; combinational from the digit index and the display register.
cat_out  output  7  cathodes, active-low, registered; bit0 = a.
an_out  output  8  anodes, active-low, one-hot, registered; bit k = digit k.
pending_out  output  1  high while a captured value is waiting for commit.

Behaviour:
- Reset (synchronous, rst_in high at a clk_in edge) sets:
  - cnt = 0, d = 0, disp_reg = 0, shadow = 0.
  - pending_out = 0, an_out = 8'hFF, cat_out = 7'h7F.
  - Reset mid-frame aborts the frame immediately; any pending value is discarded.
- Slot counter:
  - cnt runs 0 .. COUNT_PERIOD-1 and wraps to 0.
  - Digit index d increments when cnt == COUNT_PERIOD-1, wrapping 7 -> 0.
- Frame boundary: the cycle where cnt == COUNT_PERIOD-1 and d == 7.
- Capture:
  - val_valid_in high: shadow <= val_in and pending <= 1.
  - A later strobe before commit overwrites shadow; last write wins.
- Commit at the frame boundary:
  - If pending: disp_reg <= shadow and pending <= 0.
  - If val_valid_in is high in the same boundary cycle: bypass, so disp_reg <= val_in, shadow <= val_in, pending <= 0.
  - The new value is first shown in the slot with d = 0.
- nibble_out = disp_reg[4d+3:4d], with no register stage.
- Per-slot phases, from cnt:
  - BLANK phase (cnt < BLANK_CYCLES): drive is off.
  - DRIVE phase (cnt >= BLANK_CYCLES): drive is on.
  - If BLANK_CYCLES = 0, every cycle is DRIVE.
- Suppression: digit d is suppressed when LZ_BLANK = 1, d != 0, and disp_reg[31:4d] == 0. Digit 0 is never suppressed, so the value 0 shows a single "0".
- Output registers, 1-cycle latency; updated each cycle from that cycle's cnt, d and seg_in:
  - When DRIVE and not suppressed: an_out <= ~(8'b1 << d) and cat_out <= ~seg_in.
  - Otherwise: an_out <= 8'hFF and cat_out <= 7'h7F.
- At most one anode is ever low. An anode never stays low across a digit change: the slot opens with BLANK, or with the registered transition when BLANK_CYCLES = 0.
- Width rules:
  - cnt is $clog2(COUNT_PERIOD) bits wide.
  - d is 3 bits and wraps naturally.
  - No arithmetic overflow paths exist beyond these wraps.

Test Plan:
Bench uses COUNT_PERIOD=8, BLANK_CYCLES=2, LZ_BLANK=1 unless stated, with a behavioural decoder model on seg_in.
1. Reset, then idle -> an_out == 8'hFF for 2 cycles of each slot. Digit 0 asserts an_out = 8'hFE and cat_out = 7'b1000000 ("0") for cycles 3-8 after reset. Digits 1-7 stay dark (suppressed).
2. Strobe val_in = 32'h0000_00A5 mid-frame -> pending_out = 1 until the next frame boundary. Then digit 0 shows "5" and digit 1 shows "A" (an_out = 8'hFD). Digits 2-7 stay dark.
3. Strobe 32'h8765_4321, then 32'h1234_5678 before the boundary -> only 1234_5678 is ever displayed. Digit 7 shows "1" with an_out = 8'h7F.
4. Strobe in the exact boundary cycle -> bypass: the value appears in the immediately following digit-0 slot and pending_out stays 0.
5. LZ_BLANK = 0 with val_in = 0 -> all 8 digits show "0" in sequence. The one-hot anode check holds every cycle.
6. rst_in asserted mid-slot while pending -> the next cycle has an_out = 8'hFF, cat_out = 7'h7F and pending_out = 0. After release, digit 0 shows "0".
